branch_resolve_unit: RTL and testbench

//  Consumer side of the EX-stage ALU flag interface: takes Zero/Negative/Carry/OverFlow plus the

---
 rtl/branch_resolve_unit_if.sv | 44 ++++
 rtl/branch_resolve_unit.sv | 148 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Interface between the EX-stage decode/ALU flags and the branch resolve unit.
// The master drives the EX-side fields. The slave is the resolve unit, which
// returns the registered M-stage redirect, flush and status outputs.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            branch_e;
    logic            jump_e;
    logic            jalr_e;
    logic [2:0]      funct3_e;
    logic            Zero;
    logic            Negative;
    logic            Carry;
    logic            OverFlow;
    logic [XLEN-1:0] pc_e;
    logic [XLEN-1:0] imm_e;
    logic [XLEN-1:0] alu_result_e;

    logic            pc_src_m;
    logic [XLEN-1:0] pc_target_m;
    logic            flush_d;
    logic            flush_e;
    logic            misalign_m;
    logic            illegal_br_m;
    logic [31:0]     br_count_o;
    logic [31:0]     br_taken_o;

    modport master (
        output ex_valid, branch_e, jump_e, jalr_e, funct3_e,
        output Zero, Negative, Carry, OverFlow,
        output pc_e, imm_e, alu_result_e,
        input  pc_src_m, pc_target_m, flush_d, flush_e,
        input  misalign_m, illegal_br_m, br_count_o, br_taken_o
    );

    modport slave (
        input  ex_valid, branch_e, jump_e, jalr_e, funct3_e,
        input  Zero, Negative, Carry, OverFlow,
        input  pc_e, imm_e, alu_result_e,
        output pc_src_m, pc_target_m, flush_d, flush_e,
        output misalign_m, illegal_br_m, br_count_o, br_taken_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves conditional branches, JAL and JALR in EX from
// the ALU flags. It registers the PC redirect and the pipeline flushes into M.
// After each redirect it runs a shadow window. In that window, wrong-path EX
// instructions are ignored.
// Optional feature: define BR_STATS_EN to build the branch statistics counters.
// When it is undefined, br_count_o and br_taken_o are tied to zero.
module branch_resolve_unit #(
    parameter int XLEN          = 32,
    parameter int SHADOW_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    branch_resolve_unit_if.slave bus
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_REDIR  = 2'd1;
    localparam logic [1:0] ST_SHADOW = 2'd2;

    logic [1:0]      state;
    logic [1:0]      shadow_cnt;
    logic            redir_q;
    logic            misalign_q;
    logic            illegal_q;
    logic [XLEN-1:0] target_q;

    logic            sel_jalr;
    logic            sel_jump;
    logic            sel_branch;
    logic            cond;
    logic            illegal_cond;
    logic            taken;
    logic            misaligned;
    logic [XLEN-1:0] target;

    // JALR clears bit 0 of the target, so the ALU LSB never reaches any logic.
    logic            unused_alu_lsb;
    assign unused_alu_lsb = bus.alu_result_e[0];

    // Decode the EX instruction: priority select, branch condition, target and alignment
    always_comb begin
        sel_jalr     = bus.ex_valid & bus.jalr_e;
        sel_jump     = bus.ex_valid & ~bus.jalr_e & bus.jump_e;
        sel_branch   = bus.ex_valid & ~bus.jalr_e & ~bus.jump_e & bus.branch_e;
        cond         = 1'b0;
        illegal_cond = 1'b0;
        case (bus.funct3_e)
            3'b000:  cond = bus.Zero;
            3'b001:  cond = ~bus.Zero;
            3'b100:  cond = bus.Negative ^ bus.OverFlow;
            3'b101:  cond = ~(bus.Negative ^ bus.OverFlow);
            3'b110:  cond = ~bus.Carry;
            3'b111:  cond = bus.Carry;
            default: illegal_cond = 1'b1;
        endcase
        if (sel_jalr) begin
            target = {bus.alu_result_e[XLEN-1:1], 1'b0};
        end else begin
            target = bus.pc_e + bus.imm_e;
        end
        taken      = sel_jalr | sel_jump | (sel_branch & cond);
        misaligned = (target[1:0] != 2'b00);
    end

    // Redirect FSM plus registered M-stage outputs; everything freezes while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            shadow_cnt <= 2'd0;
            redir_q    <= 1'b0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            target_q   <= '0;
        end else if (!stall_i) begin
            redir_q    <= 1'b0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (sel_branch && illegal_cond) begin
                        illegal_q <= 1'b1;
                    end
                    if (taken) begin
                        if (misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            redir_q  <= 1'b1;
                            target_q <= target;
                            state    <= ST_REDIR;
                        end
                    end
                end
                ST_REDIR: begin
                    if (SHADOW_CYCLES > 0) begin
                        state      <= ST_SHADOW;
                        shadow_cnt <= 2'(SHADOW_CYCLES);
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_SHADOW: begin
                    if (shadow_cnt <= 2'd1) begin
                        state      <= ST_RUN;
                        shadow_cnt <= 2'd0;
                    end else begin
                        shadow_cnt <= shadow_cnt - 2'd1;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    shadow_cnt <= 2'd0;
                end
            endcase
        end
    end

    assign bus.pc_src_m     = redir_q;
    assign bus.flush_d      = redir_q;
    assign bus.flush_e      = redir_q;
    assign bus.pc_target_m  = target_q;
    assign bus.misalign_m   = misalign_q;
    assign bus.illegal_br_m = illegal_q;

`ifdef BR_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] br_taken_q;

    // Count valid conditional branches resolved in RUN (illegal ones included) and the aligned taken subset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count_q <= 32'd0;
            br_taken_q <= 32'd0;
        end else if (!stall_i && (state == ST_RUN) && sel_branch) begin
            br_count_q <= br_count_q + 32'd1;
            if (cond && !misaligned) begin
                br_taken_q <= br_taken_q + 32'd1;
            end
        end
    end

    assign bus.br_count_o = br_count_q;
    assign bus.br_taken_o = br_taken_q;
`else
    assign bus.br_count_o = 32'd0;
    assign bus.br_taken_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit.
// Flags are derived from ALU operands A and B. The reference model decides
// branches with plain signed and unsigned comparisons of A and B. The redirect
// window is modelled as a count of ignored cycles.
module tb_branch_resolve_unit;
    localparam int XLEN = 32;
    localparam int SC   = 1;

    logic        clk;
    logic        rst;
    logic        stall_i;
    int          checks;
    int          errors;
    logic [31:0] opA;
    logic [31:0] opB;

    logic        m_src;
    logic        m_mis;
    logic        m_ill;
    logic [31:0] m_target;
    logic [31:0] m_cnt;
    logic [31:0] m_tkn;
    int          m_ignore;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus();

    branch_resolve_unit #(.XLEN(XLEN), .SHADOW_CYCLES(SC)) dut (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_i),
        .bus     (bus)
    );

    // 10 ns pipeline clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic br, input logic jal, input logic jalr,
                                 input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] alu, input logic [31:0] a, input logic [31:0] b,
                                 input logic st);
        logic [31:0] diff;
        diff             = a - b;
        opA              = a;
        opB              = b;
        bus.ex_valid     = v;
        bus.branch_e     = br;
        bus.jump_e       = jal;
        bus.jalr_e       = jalr;
        bus.funct3_e     = f3;
        bus.pc_e         = pc;
        bus.imm_e        = imm;
        bus.alu_result_e = alu;
        bus.Zero         = (a == b);
        bus.Negative     = diff[31];
        bus.Carry        = (a >= b);
        bus.OverFlow     = (a[31] != b[31]) && (diff[31] != a[31]);
        stall_i          = st;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_src    = 1'b0;
        m_mis    = 1'b0;
        m_ill    = 1'b0;
        m_target = 32'd0;
        m_cnt    = 32'd0;
        m_tkn    = 32'd0;
        m_ignore = 0;
    endtask

    task automatic modelStep();
        logic [31:0] tgt;
        logic        taken;
        logic        isBranch;
        tgt      = 32'd0;
        taken    = 1'b0;
        isBranch = 1'b0;
        if (stall_i) return;
        m_src = 1'b0;
        m_mis = 1'b0;
        m_ill = 1'b0;
        if (m_ignore > 0) begin
            m_ignore--;
            return;
        end
        if (!bus.ex_valid) return;
        if (bus.jalr_e) begin
            tgt   = bus.alu_result_e & 32'hFFFF_FFFE;
            taken = 1'b1;
        end else if (bus.jump_e) begin
            tgt   = bus.pc_e + bus.imm_e;
            taken = 1'b1;
        end else if (bus.branch_e) begin
            isBranch = 1'b1;
            tgt      = bus.pc_e + bus.imm_e;
            m_cnt    = m_cnt + 32'd1;
            case (bus.funct3_e)
                3'd0:    taken = (opA == opB);
                3'd1:    taken = (opA != opB);
                3'd4:    taken = ($signed(opA) < $signed(opB));
                3'd5:    taken = ($signed(opA) >= $signed(opB));
                3'd6:    taken = (opA < opB);
                3'd7:    taken = (opA >= opB);
                default: m_ill = 1'b1;
            endcase
        end
        if (taken) begin
            if (tgt[1:0] != 2'b00) begin
                m_mis = 1'b1;
            end else begin
                m_src    = 1'b1;
                m_target = tgt;
                m_ignore = 1 + SC;
                if (isBranch) m_tkn = m_tkn + 32'd1;
            end
        end
    endtask

    task automatic checkAllOutputs();
        checkOutput("pc_src_m",     32'(bus.pc_src_m),     32'(m_src));
        checkOutput("pc_target_m",  bus.pc_target_m,       m_target);
        checkOutput("flush_d",      32'(bus.flush_d),      32'(m_src));
        checkOutput("flush_e",      32'(bus.flush_e),      32'(m_src));
        checkOutput("misalign_m",   32'(bus.misalign_m),   32'(m_mis));
        checkOutput("illegal_br_m", 32'(bus.illegal_br_m), 32'(m_ill));
`ifdef BR_STATS_EN
        checkOutput("br_count_o",   bus.br_count_o,        m_cnt);
        checkOutput("br_taken_o",   bus.br_taken_o,        m_tkn);
`else
        checkOutput("br_count_o",   bus.br_count_o,        32'd0);
        checkOutput("br_taken_o",   bus.br_taken_o,        32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        #1;
        checkAllOutputs();
    endtask

    // Directed steps first, then a randomized run against the reference model
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAllOutputs();
        @(negedge clk);
        rst = 1'b1;

        // BEQ taken
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'd0, 32'd7, 32'd7, 1'b0);
        step();
        checkOutput("beq_src", 32'(bus.pc_src_m), 32'd1);
        checkOutput("beq_target", bus.pc_target_m, 32'h120);
        idle();
        repeat (2) step();

        // BLTU with A>=B is not taken
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h180, 32'h40, 32'd0, 32'd5, 32'd3, 1'b0);
        step();
        checkOutput("bltu_not_taken", 32'(bus.pc_src_m), 32'd0);

        // N=1,V=1: BGE taken
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'h200, 32'h40, 32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step();
        checkOutput("bge_taken", 32'(bus.pc_src_m), 32'd1);
        checkOutput("bge_target", bus.pc_target_m, 32'h240);
        idle();
        repeat (2) step();

        // N=1,V=1: BLT not taken
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h200, 32'h40, 32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step();
        checkOutput("blt_not_taken", 32'(bus.pc_src_m), 32'd0);

        // JALR to a misaligned target, then to an aligned one
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h203, 32'd0, 32'd0, 1'b0);
        step();
        checkOutput("jalr_misalign", 32'(bus.misalign_m), 32'd1);
        checkOutput("jalr_mis_nosrc", 32'(bus.pc_src_m), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h205, 32'd0, 32'd0, 1'b0);
        step();
        checkOutput("jalr_src", 32'(bus.pc_src_m), 32'd1);
        checkOutput("jalr_target", bus.pc_target_m, 32'h204);
        idle();
        repeat (2) step();

        // Taken branch followed by a wrong-path JAL, which must be ignored
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h300, 32'h10, 32'd0, 32'd9, 32'd9, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h400, 32'h8, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        checkOutput("shadow_jal_ignored", 32'(bus.pc_src_m), 32'd0);
        idle();
        repeat (2) step();
        checkOutput("shadow_target_kept", bus.pc_target_m, 32'h310);

        // Stall during REDIR stretches the pulse
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'h500, 32'h44, 32'd0, 32'd1, 32'd2, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h800, 32'h4, 32'd0, 32'd0, 32'd0, 1'b1);
            step();
            checkOutput("stall_hold_src", 32'(bus.pc_src_m), 32'd1);
        end
        idle();
        step();
        checkOutput("stall_release_src", 32'(bus.pc_src_m), 32'd0);
        step();

        // Illegal branch condition
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h600, 32'h8, 32'd0, 32'd1, 32'd1, 1'b0);
        step();
        checkOutput("illegal_flag", 32'(bus.illegal_br_m), 32'd1);
        idle();
        step();

        // Asynchronous reset in the middle of REDIR
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h700, 32'h10, 32'd0, 32'd4, 32'd4, 1'b0);
        step();
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkAllOutputs();
        checkOutput("async_reset_src", 32'(bus.pc_src_m), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // A JAL whose target wraps must redirect at once after reset
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        checkOutput("post_reset_src", 32'(bus.pc_src_m), 32'd1);
        checkOutput("wrap_target", bus.pc_target_m, 32'h10);
        idle();
        repeat (2) step();

        $display("[TB] directed steps done, starting random run");
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            logic [31:0] imm;
            logic [31:0] alu;
            logic [31:0] a;
            logic [31:0] b;
            logic [2:0]  kind;
            logic        v;
            logic        st;
            pc   = $urandom;
            imm  = $urandom;
            alu  = $urandom;
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) alu[1] = 1'b0;
            kind = 3'($urandom_range(0, 7));
            v    = ($urandom_range(0, 9) != 0);
            st   = ($urandom_range(0, 7) == 0);
            applyStimulus(v, (kind < 3'd5) || (kind == 3'd7), (kind == 3'd5) || (kind == 3'd7),
                          (kind == 3'd6) || (kind == 3'd7), 3'($urandom_range(0, 7)),
                          pc, imm, alu, a, b, st);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
